// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, 64x32 register file and D/E pipeline register
// Optional macro DECODE_WB_BYPASS_EN: same-cycle writeback-to-read bypass in the register file.
module decode_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  output logic        o_if_stall,
  input  logic        i_wb_we,
  input  logic [5:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_ex_busy,
  input  logic        i_redirect,
  output logic [31:0] o_pc,
  output logic [5:0]  o_instr,
  output logic [1:0]  o_op_type,
  output logic [31:0] o_de_s,
  output logic [5:0]  o_de_rs,
  output logic [31:0] o_de_t,
  output logic [5:0]  o_de_rt,
  output logic [5:0]  o_de_rd,
  output logic        o_de_we,
  output logic [31:0] o_imm,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_is_jr,
  output logic        o_start,
  output logic        o_hazard
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_FPU   = 6'h11;
  localparam logic [5:0] OP_IN    = 6'h1A;
  localparam logic [5:0] OP_OUT   = 6'h1B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW_S  = 6'h31;
  localparam logic [5:0] OP_SW_S  = 6'h39;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] OT_ALU    = 2'b00;
  localparam logic [1:0] OT_RTYPE  = 2'b01;
  localparam logic [1:0] OT_FPU    = 2'b10;
  localparam logic [1:0] OT_BUBBLE = 2'b11;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_STALL,
    ACT_LOAD,
    ACT_IDLE
  } action_t;

  logic [31:0] r_rf [64];

  logic [31:0] r_pc;
  logic [5:0]  r_instr;
  logic [1:0]  r_op_type;
  logic [31:0] r_de_s;
  logic [5:0]  r_de_rs;
  logic [31:0] r_de_t;
  logic [5:0]  r_de_rt;
  logic [5:0]  r_de_rd;
  logic        r_de_we;
  logic [31:0] r_imm;
  logic        r_branch;
  logic        r_jump;
  logic        r_is_jr;
  logic        r_start;
  logic        r_hazard;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_f_rs;
  logic [4:0]  w_f_rt;
  logic [4:0]  w_f_rd;
  logic [1:0]  w_op_type;
  logic [5:0]  w_instr;
  logic [5:0]  w_rs_idx;
  logic [5:0]  w_rt_idx;
  logic [5:0]  w_rd_idx;
  logic        w_we;
  logic        w_branch;
  logic        w_jump;
  logic        w_is_jr;
  logic        w_jal;
  logic        w_use_rs;
  logic        w_use_rt;
  logic [31:0] w_imm;
  logic [31:0] w_s_val;
  logic [31:0] w_t_val;
  logic [31:0] w_de_s;
  logic        w_de_is_load;
  logic        w_load_use;
  logic        w_wb_conflict;
  action_t     w_act;

  assign w_opcode = i_if_instr[31:26];
  assign w_f_rs   = i_if_instr[25:21];
  assign w_f_rt   = i_if_instr[20:16];
  assign w_f_rd   = i_if_instr[15:11];
  assign w_funct  = i_if_instr[5:0];

  // Integer index 0 is hard-wired to zero; float index 32 is an ordinary register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 64; i++) begin
        r_rf[i] <= '0;
      end
    end else if (i_wb_we && (i_wb_addr != 6'd0)) begin
      r_rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    w_op_type = OT_ALU;
    w_instr   = w_opcode;
    w_rs_idx  = {1'b0, w_f_rs};
    w_rt_idx  = {1'b0, w_f_rt};
    w_rd_idx  = {1'b0, w_f_rt};
    w_we      = 1'b1;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_is_jr   = 1'b0;
    w_jal     = 1'b0;
    w_use_rs  = 1'b1;
    w_use_rt  = 1'b0;
    w_imm     = {{16{i_if_instr[15]}}, i_if_instr[15:0]};
    case (w_opcode)
      OP_RTYPE: begin
        w_op_type = OT_RTYPE;
        w_instr   = w_funct;
        w_rd_idx  = {1'b0, w_f_rd};
        w_use_rt  = 1'b1;
        if (w_funct == FN_JR) begin
          w_is_jr = 1'b1;
          w_we    = 1'b0;
        end
      end
      OP_FPU: begin
        w_op_type = OT_FPU;
        w_instr   = w_funct;
        w_rs_idx  = {1'b1, w_f_rs};
        w_rt_idx  = {1'b1, w_f_rt};
        w_rd_idx  = {1'b1, w_f_rd};
        w_use_rt  = 1'b1;
      end
      OP_J: begin
        w_imm    = {6'd0, i_if_instr[25:0]};
        w_jump   = 1'b1;
        w_we     = 1'b0;
        w_use_rs = 1'b0;
      end
      OP_JAL: begin
        w_imm    = {6'd0, i_if_instr[25:0]};
        w_jump   = 1'b1;
        w_jal    = 1'b1;
        w_rd_idx = 6'd31;
        w_use_rs = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        w_branch = 1'b1;
        w_we     = 1'b0;
        w_use_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        w_branch = 1'b1;
        w_we     = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_imm = {16'd0, i_if_instr[15:0]};
      end
      OP_SW, OP_OUT: begin
        w_we     = 1'b0;
        w_use_rt = 1'b1;
      end
      OP_SW_S: begin
        w_we     = 1'b0;
        w_rt_idx = {1'b1, w_f_rt};
        w_use_rt = 1'b1;
      end
      OP_LW_S: begin
        w_rd_idx = {1'b1, w_f_rt};
      end
      OP_IN: begin
        w_use_rs = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    w_s_val = (w_rs_idx == 6'd0) ? 32'd0 : r_rf[w_rs_idx];
    w_t_val = (w_rt_idx == 6'd0) ? 32'd0 : r_rf[w_rt_idx];
`ifdef DECODE_WB_BYPASS_EN
    if (i_wb_we && (i_wb_addr != 6'd0) && (i_wb_addr == w_rs_idx)) begin
      w_s_val = i_wb_data;
    end
    if (i_wb_we && (i_wb_addr != 6'd0) && (i_wb_addr == w_rt_idx)) begin
      w_t_val = i_wb_data;
    end
`endif
  end

  assign w_de_s = w_jal ? (i_if_pc + 32'd4) : w_s_val;

  assign w_de_is_load = (r_op_type == OT_ALU) && ((r_instr == OP_LW) || (r_instr == OP_LW_S))
                        && r_de_we && (r_de_rd != 6'd0);
  assign w_load_use   = i_if_valid && w_de_is_load &&
                        ((w_use_rs && (w_rs_idx == r_de_rd)) || (w_use_rt && (w_rt_idx == r_de_rd)));

`ifdef DECODE_WB_BYPASS_EN
  assign w_wb_conflict = 1'b0;
`else
  // Without the bypass a same-cycle write would be read stale; wait for it to land.
  assign w_wb_conflict = i_if_valid && i_wb_we && (i_wb_addr != 6'd0) &&
                         ((w_use_rs && (w_rs_idx == i_wb_addr)) || (w_use_rt && (w_rt_idx == i_wb_addr)));
`endif

  always_comb begin
    w_act = ACT_IDLE;
    if (i_rst) begin
      w_act = ACT_RESET;
    end else if (i_redirect) begin
      w_act = ACT_FLUSH;
    end else if (i_ex_busy) begin
      w_act = ACT_HOLD;
    end else if (w_load_use || w_wb_conflict) begin
      w_act = ACT_STALL;
    end else if (i_if_valid) begin
      w_act = ACT_LOAD;
    end
  end

  assign o_if_stall = (w_act == ACT_HOLD) || (w_act == ACT_STALL);

  always_ff @(posedge i_clk) begin
    if (i_rst || (w_act != ACT_HOLD && w_act != ACT_LOAD)) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_op_type <= OT_BUBBLE;
      r_de_s    <= '0;
      r_de_rs   <= '0;
      r_de_t    <= '0;
      r_de_rt   <= '0;
      r_de_rd   <= '0;
      r_de_we   <= 1'b0;
      r_imm     <= '0;
      r_branch  <= 1'b0;
      r_jump    <= 1'b0;
      r_is_jr   <= 1'b0;
      r_start   <= 1'b0;
      r_hazard  <= (w_act == ACT_STALL);
    end else if (w_act == ACT_HOLD) begin
      r_start  <= 1'b0;
      r_hazard <= 1'b0;
    end else begin
      r_pc      <= i_if_pc;
      r_instr   <= w_instr;
      r_op_type <= w_op_type;
      r_de_s    <= w_de_s;
      r_de_rs   <= w_rs_idx;
      r_de_t    <= w_t_val;
      r_de_rt   <= w_rt_idx;
      r_de_rd   <= w_rd_idx;
      r_de_we   <= w_we;
      r_imm     <= w_imm;
      r_branch  <= w_branch;
      r_jump    <= w_jump;
      r_is_jr   <= w_is_jr;
      r_start   <= 1'b1;
      r_hazard  <= 1'b0;
    end
  end

  assign o_pc      = r_pc;
  assign o_instr   = r_instr;
  assign o_op_type = r_op_type;
  assign o_de_s    = r_de_s;
  assign o_de_rs   = r_de_rs;
  assign o_de_t    = r_de_t;
  assign o_de_rt   = r_de_rt;
  assign o_de_rd   = r_de_rd;
  assign o_de_we   = r_de_we;
  assign o_imm     = r_imm;
  assign o_branch  = r_branch;
  assign o_jump    = r_jump;
  assign o_is_jr   = r_is_jr;
  assign o_start   = r_start;
  assign o_hazard  = r_hazard;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, wb_we, ex_busy, redirect;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [5:0]  wb_addr;
  logic        o_if_stall, o_de_we, o_branch, o_jump, o_is_jr, o_start, o_hazard;
  logic [31:0] o_pc, o_de_s, o_de_t, o_imm;
  logic [5:0]  o_instr, o_de_rs, o_de_rt, o_de_rd;
  logic [1:0]  o_op_type;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_instr(if_instr),
    .o_if_stall(o_if_stall), .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_busy(ex_busy), .i_redirect(redirect), .o_pc(o_pc), .o_instr(o_instr),
    .o_op_type(o_op_type), .o_de_s(o_de_s), .o_de_rs(o_de_rs), .o_de_t(o_de_t),
    .o_de_rt(o_de_rt), .o_de_rd(o_de_rd), .o_de_we(o_de_we), .o_imm(o_imm),
    .o_branch(o_branch), .o_jump(o_jump), .o_is_jr(o_is_jr), .o_start(o_start),
    .o_hazard(o_hazard)
  );

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  instr;
    logic [1:0]  op_type;
    logic [31:0] s;
    logic [5:0]  rs;
    logic [31:0] t;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        br, jmp, jr, start, hz, usr, ust;
  } stage_t;

  stage_t      m;
  logic [31:0] mrf [64];
  bit          armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [5:0] idx);
    if (idx == 6'd0) return 32'd0;
    if (BYPASS && wb_we && wb_addr == idx) return wb_data;
    return mrf[idx];
  endfunction

  function automatic stage_t bubble();
    stage_t b;
    b = '0;
    b.op_type = 2'b11;
    return b;
  endfunction

  function automatic stage_t mdecode();
    stage_t d;
    logic [5:0] op, fn;
    logic [4:0] frs, frt, frd;
    logic is_r, is_f;
    d = '0;
    op = if_instr[31:26]; fn = if_instr[5:0];
    frs = if_instr[25:21]; frt = if_instr[20:16]; frd = if_instr[15:11];
    is_r = (op == 6'h00);
    is_f = (op == 6'h11);
    d.pc      = if_pc;
    d.op_type = is_r ? 2'b01 : (is_f ? 2'b10 : 2'b00);
    d.instr   = (is_r || is_f) ? fn : op;
    d.rs      = {is_f, frs};
    d.rt      = {is_f || op == 6'h39, frt};
    if (op == 6'h03)           d.rd = 6'd31;
    else if (is_r || is_f)     d.rd = {is_f, frd};
    else                       d.rd = {op == 6'h31, frt};
    d.br  = op inside {6'h04, 6'h05, 6'h06, 6'h07};
    d.jmp = op inside {6'h02, 6'h03};
    d.jr  = is_r && fn == 6'h08;
    d.we  = !(d.br || d.jr || op inside {6'h02, 6'h2B, 6'h39, 6'h1B});
    if (op inside {6'h0C, 6'h0D, 6'h0E}) d.imm = {16'd0, if_instr[15:0]};
    else if (d.jmp)                      d.imm = {6'd0, if_instr[25:0]};
    else                                 d.imm = {{16{if_instr[15]}}, if_instr[15:0]};
    d.usr   = !(op inside {6'h02, 6'h03, 6'h1A});
    d.ust   = is_r || is_f || op inside {6'h04, 6'h05, 6'h2B, 6'h39, 6'h1B};
    d.s     = (op == 6'h03) ? if_pc + 32'd4 : mread(d.rs);
    d.t     = mread(d.rt);
    d.start = 1'b1;
    return d;
  endfunction

  function automatic bit mconflict();
    stage_t d;
    bit ld, lu, wbc;
    if (!if_valid) return 1'b0;
    d   = mdecode();
    ld  = m.op_type == 2'b00 && (m.instr == 6'h23 || m.instr == 6'h31) && m.we && m.rd != 0;
    lu  = ld && ((d.usr && d.rs == m.rd) || (d.ust && d.rt == m.rd));
    wbc = !BYPASS && wb_we && wb_addr != 0 &&
          ((d.usr && d.rs == wb_addr) || (d.ust && d.rt == wb_addr));
    return lu || wbc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mrf[i] = 32'd0;
      m = bubble();
      armed = 1'b1;
    end else begin
      if (redirect)         m = bubble();
      else if (ex_busy)     begin m.start = 1'b0; m.hz = 1'b0; end
      else if (mconflict()) begin m = bubble(); m.hz = 1'b1; end
      else if (if_valid)    m = mdecode();
      else                  m = bubble();
      if (wb_we && wb_addr != 6'd0) mrf[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pc", o_pc, m.pc);
      chk("instr", {26'd0, o_instr}, {26'd0, m.instr});
      chk("op_type", {30'd0, o_op_type}, {30'd0, m.op_type});
      chk("de_s", o_de_s, m.s);
      chk("de_rs", {26'd0, o_de_rs}, {26'd0, m.rs});
      chk("de_t", o_de_t, m.t);
      chk("de_rt", {26'd0, o_de_rt}, {26'd0, m.rt});
      chk("de_rd", {26'd0, o_de_rd}, {26'd0, m.rd});
      chk("de_we", {31'd0, o_de_we}, {31'd0, m.we});
      chk("imm", o_imm, m.imm);
      chk("flags", {27'd0, o_branch, o_jump, o_is_jr, o_start, o_hazard},
          {27'd0, m.br, m.jmp, m.jr, m.start, m.hz});
      chk("if_stall", {31'd0, o_if_stall},
          {31'd0, !rst && !redirect && (ex_busy || mconflict())});
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_f(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h11, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v; if_pc = pc; if_instr = ins;
  endtask
  task automatic wb(input logic we, input logic [5:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; ex_busy = 1'b0; redirect = 1'b0;
    put(1'b0, 32'd0, 32'd0);
    wb(1'b0, 6'd0, 32'd0);
    tick(); tick();
    chk("L_rst_op_type", {30'd0, o_op_type}, 32'd3);
    chk("L_rst_pc", o_pc, 32'd0);
    chk("L_rst_start", {31'd0, o_start}, 32'd0);
    #1 chk("L_rst_stall", {31'd0, o_if_stall}, 32'd0);
    rst = 1'b0;

    put(1'b1, 32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5)); tick();
    chk("L_addi_op_type", {30'd0, o_op_type}, 32'd0);
    chk("L_addi_imm", o_imm, 32'd5);
    chk("L_addi_rd", {26'd0, o_de_rd}, 32'd1);
    chk("L_addi_start", {31'd0, o_start}, 32'd1);
    chk("L_addi_pc", o_pc, 32'h100);

    put(1'b0, 32'd0, 32'd0);
    wb(1'b1, 6'd2, 32'h11);       tick();
    wb(1'b1, 6'd35, 32'h3f800000); tick();
    wb(1'b1, 6'd0, 32'hFFFF);     tick();
    wb(1'b0, 6'd0, 32'd0);
    chk("L_idle_bubble", {30'd0, o_op_type}, 32'd3);

    put(1'b1, 32'h104, enc_r(5'd0, 5'd0, 5'd10, 6'h20)); tick();
    chk("L_r0_reads_zero", o_de_s, 32'd0);
    put(1'b1, 32'h108, enc_f(5'd3, 5'd3, 5'd1, 6'h00)); tick();
    chk("L_fpu_op_type", {30'd0, o_op_type}, 32'd2);
    chk("L_fpu_rs", {26'd0, o_de_rs}, 32'd35);
    chk("L_fpu_s", o_de_s, 32'h3f800000);
    chk("L_fpu_rd", {26'd0, o_de_rd}, 32'd33);

    put(1'b1, 32'h110, enc_i(6'h23, 5'd1, 5'd2, 16'd0)); tick();
    put(1'b1, 32'h114, enc_r(5'd2, 5'd2, 5'd3, 6'h20));
    #1 chk("L_lu_stall", {31'd0, o_if_stall}, 32'd1);
    tick();
    chk("L_lu_bubble", {30'd0, o_op_type}, 32'd3);
    chk("L_lu_hazard", {31'd0, o_hazard}, 32'd1);
    #1 chk("L_lu_release", {31'd0, o_if_stall}, 32'd0);
    tick();
    chk("L_lu_add_instr", {26'd0, o_instr}, 32'h20);
    chk("L_lu_add_s", o_de_s, 32'h11);
    chk("L_lu_add_start", {31'd0, o_start}, 32'd1);

    put(1'b1, 32'h120, enc_i(6'h1A, 5'd0, 5'd6, 16'd0)); tick();
    chk("L_in_start", {31'd0, o_start}, 32'd1);
    put(1'b1, 32'h124, enc_i(6'h0D, 5'd0, 5'd7, 16'hF0F0));
    ex_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("L_busy_stall", {31'd0, o_if_stall}, 32'd1);
      tick();
      chk("L_busy_start", {31'd0, o_start}, 32'd0);
      chk("L_busy_hold", o_pc, 32'h120);
    end
    ex_busy = 1'b0;
    tick();
    chk("L_ori_zext", o_imm, 32'h0000F0F0);
    chk("L_ori_start", {31'd0, o_start}, 32'd1);

    put(1'b1, 32'h128, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFC)); tick();
    chk("L_beq_branch", {31'd0, o_branch}, 32'd1);
    chk("L_beq_imm", o_imm, 32'hFFFFFFFC);
    put(1'b1, 32'h12C, enc_i(6'h08, 5'd0, 5'd8, 16'd1));
    redirect = 1'b1;
    #1 chk("L_redir_stall", {31'd0, o_if_stall}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("L_redir_bubble", {30'd0, o_op_type}, 32'd3);
    chk("L_redir_start", {31'd0, o_start}, 32'd0);
    put(1'b1, 32'h11C, enc_i(6'h08, 5'd0, 5'd9, 16'd2)); tick();
    chk("L_target_rd", {26'd0, o_de_rd}, 32'd9);

    put(1'b1, 32'h200, enc_j(6'h03, 26'h40)); tick();
    chk("L_jal_jump", {31'd0, o_jump}, 32'd1);
    chk("L_jal_s", o_de_s, 32'h204);
    chk("L_jal_rd", {26'd0, o_de_rd}, 32'd31);
    chk("L_jal_imm", o_imm, 32'h40);
    chk("L_jal_we", {31'd0, o_de_we}, 32'd1);
    put(1'b1, 32'h204, enc_j(6'h02, 26'h80)); tick();
    chk("L_j_we", {31'd0, o_de_we}, 32'd0);
    put(1'b1, 32'h208, enc_r(5'd31, 5'd0, 5'd0, 6'h08)); tick();
    chk("L_jr_is_jr", {31'd0, o_is_jr}, 32'd1);
    chk("L_jr_we", {31'd0, o_de_we}, 32'd0);
    put(1'b1, 32'h20C, enc_i(6'h0E, 5'd2, 5'd11, 16'h8001)); tick();
    chk("L_xori_imm", o_imm, 32'h8001);
    put(1'b1, 32'h210, enc_i(6'h2B, 5'd1, 5'd2, 16'd8)); tick();
    chk("L_sw_t", o_de_t, 32'h11);
    put(1'b1, 32'h214, enc_i(6'h31, 5'd1, 5'd4, 16'd0)); tick();
    chk("L_lws_rd", {26'd0, o_de_rd}, 32'd36);
    put(1'b1, 32'h218, enc_i(6'h39, 5'd1, 5'd3, 16'd0)); tick();
    chk("L_sws_t", o_de_t, 32'h3f800000);

    put(1'b1, 32'h300, enc_r(5'd4, 5'd0, 5'd5, 6'h20));
    wb(1'b1, 6'd4, 32'hDEADBEEF);
`ifdef DECODE_WB_BYPASS_EN
    tick();
    wb(1'b0, 6'd0, 32'd0);
`else
    #1 chk("L_wb_stall", {31'd0, o_if_stall}, 32'd1);
    tick();
    wb(1'b0, 6'd0, 32'd0);
    chk("L_wb_hazard", {31'd0, o_hazard}, 32'd1);
    tick();
`endif
    chk("L_wb_s", o_de_s, 32'hDEADBEEF);
    chk("L_wb_start", {31'd0, o_start}, 32'd1);

    put(1'b0, 32'd0, 32'd0); tick();
    put(1'b1, 32'h400, enc_i(6'h23, 5'd1, 5'd2, 16'd0)); tick();
    put(1'b1, 32'h404, enc_r(5'd2, 5'd2, 5'd3, 6'h20));
    rst = 1'b1;
    #1 chk("L_rst_stall_abandon", {31'd0, o_if_stall}, 32'd0);
    tick();
    rst = 1'b0;
    chk("L_rst_mid_hazard", {31'd0, o_hazard}, 32'd0);
    tick();
    chk("L_rst_rf_cleared", o_de_s, 32'd0);
    put(1'b0, 32'd0, 32'd0); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 Port rst, input, 1: reset, synchronous, active-high.
REQ-003 Port if_valid, input, 1: fetch presents an instruction this cycle.
REQ-004 Port if_pc, input, 32: PC of the presented instruction.
REQ-005 Port if_instr, input, 32: instruction word, fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-006 Port if_stall, output, 1: high means fetch shall hold if_pc/if_instr next cycle.
REQ-007 Ports wb_we (1), wb_addr (6), wb_data (32), inputs: writeback write port.
REQ-008 Ports ex_busy (1, UART busy from execute) and redirect (1, taken branch/jump from execute), inputs.
REQ-009 Outputs pc (32), instr (6), op_type (2), de_s (32), de_rs (6), de_t (32), de_rt (6), de_rd (6), de_we (1), imm (32), branch, jump, is_jr, start, hazard (1 each): registered D/E fields consumed by execute.

Function
REQ-010 Register file: 64x32; index 0-31 integer, 32-63 float; integer index 0 shall read 0 and ignore writes.
REQ-011 Decode: opcode 0 -> op_type 01, instr=funct; FPU opcode -> op_type 10, instr=funct, sources/dest offset by 32; otherwise op_type 00, instr=opcode.
REQ-012 imm: zero-extended imm16 for ANDI/ORI/XORI, zero-extended [25:0] for J/JAL, sign-extended imm16 otherwise.
REQ-013 JAL: de_s = if_pc+4, de_rd = 31, de_we = 1, jump = 1; J: jump = 1, de_we = 0; JR: is_jr = 1.
REQ-014 branch = 1 for BEQ/BNE/BLEZ/BGTZ; de_we = 0 for branches, SW, SW_S, OUT, JR.
REQ-015 Bubble encoding: op_type 11, instr 0, de_we 0, start 0, branch/jump/is_jr 0.
REQ-016 Priority each cycle: rst > redirect > ex_busy > load-use > advance.
REQ-017 Redirect: D/E register loads a bubble; instruction currently at if_* is discarded; if_stall = 0.
REQ-018 ex_busy high: D/E register holds all fields; start forced 0; if_stall = 1.
REQ-019 Load-use: D/E holds LW/LW_S with de_we=1 and de_rd (nonzero) equals a source of if_instr -> insert one bubble, if_stall = 1, hazard = 1 for that cycle.
REQ-020 Advance: if_valid=1 loads decoded fields with start = 1 for exactly the first cycle presented; if_valid=0 loads a bubble.
REQ-021 Held instruction re-presented under ex_busy shall keep start = 0 and hazard = 0.
REQ-022 Latency: one cycle from if_* to D/E outputs when no stall.

Reset
REQ-023 On rst: all D/E outputs take bubble encoding, pc = 0, de_s/de_t/imm = 0, hazard = 0, if_stall = 0.
REQ-024 Register file contents shall be cleared to 0 on rst; rst mid-stall abandons the stall.

Configuration
REQ-025 Macro DECODE_WB_BYPASS_EN defined: read of wb_addr while wb_we=1 returns wb_data same cycle.
REQ-026 Macro undefined: reads return stored value; hazard unit stalls one extra cycle when wb_we=1 and wb_addr matches a source.

Verification
REQ-027 rst then ADDI r1,r0,5 at pc 0x100 -> next cycle op_type 00, imm 5, de_rd 1, start 1, pc 0x100.
REQ-028 LW r2 then ADD r3,r2,r2 -> one bubble, hazard 1, if_stall 1, ADD presented following cycle.
REQ-029 IN with ex_busy held 3 cycles -> D/E stable, start 1 only first cycle, if_stall 1 for 3 cycles.
REQ-030 BEQ taken, redirect=1 with next instruction valid -> bubble issued, discarded instruction never gets start.
REQ-031 wb_we=1, wb_addr 4, wb_data 0xDEADBEEF while decoding ADD r5,r4,r0 -> de_s 0xDEADBEEF with macro; one-cycle stall then same value without.
REQ-032 JAL target 0x40 at pc 0x200 -> jump 1, de_s 0x204, de_rd 31, imm 0x40.
